// File: rtl/iomem_ctrl.sv
// iomem bus sequencer: decodes one master access by address page to a slave slot,
// runs a registered access and returns a registered response, with miss/timeout recovery.
module iomem_ctrl #(
  parameter int unsigned NSLAVES   = 4,
  parameter logic [15:0] BASE_PAGE = 16'h0300,
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] ERR_DATA  = 32'hDEADBEEF
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   m_valid,
  output logic                   m_ready,
  input  logic [31:0]            m_addr,
  input  logic [31:0]            m_wdata,
  input  logic [3:0]             m_wstrb,
  output logic [31:0]            m_rdata,
  output logic [NSLAVES-1:0]     s_valid,
  input  logic [NSLAVES-1:0]     s_ready,
  output logic [31:0]            s_addr,
  output logic [31:0]            s_wdata,
  output logic [3:0]             s_wstrb,
  input  logic [32*NSLAVES-1:0]  s_rdata,
  output logic                   err_miss,
  output logic                   err_timeout,
  output logic [7:0]             err_count
);

  localparam int unsigned IDXW = (NSLAVES > 1) ? $clog2(NSLAVES) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e              state_q, state_d;
  logic [NSLAVES-1:0]  s_valid_q, s_valid_d;
  logic [31:0]         s_addr_q, s_addr_d;
  logic [31:0]         s_wdata_q, s_wdata_d;
  logic [3:0]          s_wstrb_q, s_wstrb_d;
  logic [31:0]         m_rdata_q, m_rdata_d;
  logic [IDXW-1:0]     idx_q, idx_d;
  logic [31:0]         cnt_q, cnt_d;
  logic                err_miss_q, err_miss_d;
  logic                err_timeout_q, err_timeout_d;
  logic [7:0]          err_count_q, err_count_d;

  logic [15:0]         page_off;
  logic                hit;
  logic [NSLAVES-1:0]  dec_onehot;
  logic [31:0]         slot_rdata [NSLAVES];
  logic                sel_ready;
  logic [31:0]         sel_rdata;
  logic                timeout_hit;

  // 16-bit wrap is intentional: pages below BASE_PAGE become large offsets and miss
  assign page_off = m_addr[31:16] - BASE_PAGE;
  assign hit      = ({16'd0, page_off} < NSLAVES);

  genvar gi;
  generate
    for (gi = 0; gi < NSLAVES; gi++) begin : g_slot
      assign dec_onehot[gi] = (page_off == 16'(gi));
      assign slot_rdata[gi] = s_rdata[32*gi +: 32];
    end
  endgenerate

  // Response path keys off the latched slot, not the live master address
  assign sel_ready   = s_ready[idx_q];
  assign sel_rdata   = slot_rdata[idx_q];
  assign timeout_hit = (TIMEOUT != 0) && !sel_ready && (cnt_q == TIMEOUT - 1);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      s_valid_q     <= '0;
      s_addr_q      <= '0;
      s_wdata_q     <= '0;
      s_wstrb_q     <= '0;
      m_rdata_q     <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      err_miss_q    <= 1'b0;
      err_timeout_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      s_valid_q     <= s_valid_d;
      s_addr_q      <= s_addr_d;
      s_wdata_q     <= s_wdata_d;
      s_wstrb_q     <= s_wstrb_d;
      m_rdata_q     <= m_rdata_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      err_miss_q    <= err_miss_d;
      err_timeout_q <= err_timeout_d;
      err_count_q   <= err_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (m_valid) state_d = hit ? ACCESS : RESP;
      ACCESS:  if (sel_ready || timeout_hit) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_valid_d     = s_valid_q;
    s_addr_d      = s_addr_q;
    s_wdata_d     = s_wdata_q;
    s_wstrb_d     = s_wstrb_q;
    m_rdata_d     = m_rdata_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    err_miss_d    = 1'b0;
    err_timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_valid) begin
          s_addr_d  = m_addr;
          s_wdata_d = m_wdata;
          s_wstrb_d = m_wstrb;
          cnt_d     = '0;
          if (hit) begin
            s_valid_d = dec_onehot;
            idx_d     = page_off[IDXW-1:0];
          end else begin
            m_rdata_d  = ERR_DATA;
            err_miss_d = 1'b1;
          end
        end
      end
      ACCESS: begin
        if (sel_ready) begin
          m_rdata_d = sel_rdata;
          s_valid_d = '0;
          cnt_d     = '0;
        end else if (timeout_hit) begin
          m_rdata_d     = ERR_DATA;
          s_valid_d     = '0;
          cnt_d         = '0;
          err_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: ;
    endcase
    err_count_d = err_count_q;
    if ((err_miss_d || err_timeout_d) && (err_count_q != 8'hFF))
      err_count_d = err_count_q + 8'd1;
  end

  always_comb begin
    m_ready     = (state_q == RESP);
    m_rdata     = m_rdata_q;
    s_valid     = s_valid_q;
    s_addr      = s_addr_q;
    s_wdata     = s_wdata_q;
    s_wstrb     = s_wstrb_q;
    err_miss    = err_miss_q;
    err_timeout = err_timeout_q;
    err_count   = err_count_q;
  end

endmodule

// File: tb/tb_iomem_ctrl.sv
// Randomized bench for iomem_ctrl: per-transaction expectations come from the
// address-page / latency / timeout rules, with the bench playing all slaves.
module tb_iomem_ctrl;

  localparam int          NS  = 4;
  localparam int          TMO = 8;
  localparam logic [31:0] ERR = 32'hDEADBEEF;

  logic              clk = 1'b0;
  logic              rstn;
  logic              m_valid;
  logic              m_ready;
  logic [31:0]       m_addr;
  logic [31:0]       m_wdata;
  logic [3:0]        m_wstrb;
  logic [31:0]       m_rdata;
  logic [NS-1:0]     s_valid;
  logic [NS-1:0]     s_ready;
  logic [31:0]       s_addr;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic [32*NS-1:0]  s_rdata;
  logic              err_miss;
  logic              err_timeout;
  logic [7:0]        err_count;

  int n_checks = 0;
  int n_fails  = 0;
  int model_errs = 0;

  iomem_ctrl #(
    .NSLAVES(NS), .BASE_PAGE(16'h0300), .TIMEOUT(TMO), .ERR_DATA(ERR)
  ) dut (
    .clk(clk), .rstn(rstn),
    .m_valid(m_valid), .m_ready(m_ready), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_rdata(s_rdata),
    .err_miss(err_miss), .err_timeout(err_timeout), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One master transaction; slave 'delay' = access cycles before its ready rises.
  task automatic do_txn(input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input int delay, input bit hold);
    logic [15:0] off;
    bit          hit;
    bit          to;
    int          slot;
    int          lat;
    logic [31:0] exp_rd;
    logic [3:0]  oh;
    logic [3:0]  noise;
    logic [31:0] rd [NS];
    int          cnt_before;
    off  = addr[31:16] - 16'h0300;
    hit  = (off < 16'(NS));
    slot = hit ? int'(off) : 0;
    to   = 1'b0;
    for (int i = 0; i < NS; i++) rd[i] = $urandom;
    s_rdata = {rd[3], rd[2], rd[1], rd[0]};
    if (!hit) begin
      lat = 1; exp_rd = ERR;
    end else if (delay < TMO) begin
      lat = delay + 2; exp_rd = rd[slot];
    end else begin
      lat = TMO + 1; exp_rd = ERR; to = 1'b1;
    end
    oh = hit ? (4'b0001 << slot) : 4'b0000;
    cnt_before = model_errs;
    if ((!hit || to) && model_errs < 255) model_errs++;

    m_valid = 1'b1; m_addr = addr; m_wdata = wdata; m_wstrb = wstrb; s_ready = '0;
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      if (!hold) m_valid = 1'b0;
      check("m_ready", 32'(m_ready), 32'(c == lat));
      check("s_valid", 32'(s_valid), 32'((c < lat) ? oh : 4'b0000));
      check("s_addr", s_addr, addr);
      check("s_wdata", s_wdata, wdata);
      check("s_wstrb", 32'(s_wstrb), 32'(wstrb));
      check("err_miss", 32'(err_miss), 32'(!hit && c == lat));
      check("err_timeout", 32'(err_timeout), 32'(to && c == lat));
      check("err_count", 32'(err_count), 32'((c == lat) ? model_errs : cnt_before));
      if (c == lat) begin
        check("m_rdata", m_rdata, exp_rd);
        m_valid = 1'b0;
        s_ready = '0;
      end else begin
        noise   = 4'($urandom_range(0, 15)) & ~oh;
        s_ready = noise | ((c - 1 >= delay) ? oh : 4'b0000);
      end
    end
    $display("txn addr=%h wstrb=%h delay=%0d lat=%0d rdata=%h errs=%0d",
             addr, wstrb, delay, lat, m_rdata, err_count);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    rstn = 1'b0; m_valid = 1'b0; m_addr = '0; m_wdata = '0; m_wstrb = '0;
    s_ready = '0; s_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_ready", 32'(m_ready), 32'd0);
    check("rst_m_rdata", m_rdata, 32'd0);
    check("rst_s_valid", 32'(s_valid), 32'd0);
    check("rst_s_addr", s_addr, 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    rstn = 1'b1;

    do_txn(32'h0300_0004, 32'h0, 4'h0, 0, 1'b0);
    do_txn(32'h0302_0000, 32'hA5A5_A5A5, 4'hF, 5, 1'b1);
    do_txn(32'h0400_0000, 32'h0, 4'h0, 0, 1'b0);
    do_txn(32'h0301_0010, 32'h0, 4'h0, 100, 1'b0);
    do_txn(32'h0301_0020, 32'h0, 4'h0, TMO - 1, 1'b0);
    do_txn(32'h02FF_0000, 32'h0, 4'h0, 0, 1'b0);

    // Reset while slot 3 is mid-access
    m_valid = 1'b1; m_addr = 32'h0303_0008; m_wdata = '0; m_wstrb = '0; s_ready = '0;
    @(posedge clk); #1;
    m_valid = 1'b0;
    check("rst_mid_s_valid_pre", 32'(s_valid), 32'h8);
    @(posedge clk); #2;
    rstn = 1'b0;
    #1;
    check("rst_mid_s_valid", 32'(s_valid), 32'd0);
    check("rst_mid_m_ready", 32'(m_ready), 32'd0);
    check("rst_mid_err_count", 32'(err_count), 32'd0);
    model_errs = 0;
    @(posedge clk); #1;
    rstn = 1'b1;
    do_txn(32'h0303_0008, 32'h0, 4'h0, 1, 1'b0);

    for (int t = 0; t < 200; t++) begin
      if ($urandom_range(0, 9) < 7)
        a = {16'h0300 + 16'($urandom_range(0, NS - 1)), 16'($urandom)};
      else
        a = $urandom;
      do_txn(a, $urandom, ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom),
             $urandom_range(0, TMO + 3), 1'($urandom_range(0, 1)));
    end

    for (int t = 0; t < 300; t++) do_txn(32'h0500_0000 + 32'(t), 32'h0, 4'h0, 0, 1'b0);
    check("sat_err_count", 32'(err_count), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
